// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: difference and borrow-out for x - y - bin.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, reporting
// the difference, unsigned borrow and signed overflow with a one-cycle done pulse.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_nextState;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_aMsb;
   logic             r_bMsb;
   logic             r_bin;
   logic             r_borrow;
   logic             r_ovf;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_lastBit;
   logic             w_d;
   logic             w_bout;

   // Start is honoured only when no operation is in flight.
   assign w_accept  = start && (r_state != SHIFT);
   assign w_lastBit = (r_state == SHIFT) && (r_cnt == LAST);

   full_subtractor u_fullSub (
      .x    (r_a[0]),
      .y    (r_b[0]),
      .bin  (r_bin),
      .d    (w_d),
      .bout (w_bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = SHIFT;
         SHIFT:   if (w_lastBit) w_nextState = DONE;
         DONE:    w_nextState = start ? SHIFT : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == SHIFT);
      done = (r_state == DONE);
   end

   // Difference bits enter from the MSB side so the word is aligned after WIDTH shifts;
   // published results only change on the final bit, so they hold through the next operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_aMsb   <= 1'b0;
         r_bMsb   <= 1'b0;
         r_bin    <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a    <= a;
         r_b    <= b;
         r_res  <= '0;
         r_aMsb <= a[WIDTH-1];
         r_bMsb <= b[WIDTH-1];
         r_bin  <= 1'b0;
         r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= {w_d, r_res[WIDTH-1:1]};
         r_bin <= w_bout;
         r_cnt <= r_cnt + CW'(1);
         if (w_lastBit) begin
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_ovf    <= (r_aMsb ^ r_bMsb) & (w_d ^ r_aMsb);
         end
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } expect_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   expect_t      expQ[$];
   int           checks;
   int           errors;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushExpected(input logic [W-1:0] d, input logic br, input logic ov);
      expect_t e;
      e.diff   = d;
      e.borrow = br;
      e.ovf    = ov;
      expQ.push_back(e);
   endtask

   // Drives one request so that it is accepted on the next rising edge; leaves the bench at edge+1.
   task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                input logic [W-1:0] expDiff, input logic expBorrow,
                                input logic expOvf, input bit holdStart);
      @(negedge clk);
      a     = aIn;
      b     = bIn;
      start = 1'b1;
      @(posedge clk);
      #1;
      pushExpected(expDiff, expBorrow, expOvf);
      if (!holdStart) start = 1'b0;
   endtask

   // Counts edges until done is seen, plus busy samples along the way; bounded.
   task automatic waitDone(output int edges, output int busyCnt);
      edges   = 0;
      busyCnt = busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         edges++;
         if (done) return;
         if (busy) busyCnt++;
      end
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no done expected done within 40 edges");
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone: got done=1 expected no pending result at %0t", $time);
         end else begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput("diff", int'(diff), int'(e.diff));
            checkOutput("borrow", int'(borrow), int'(e.borrow));
            checkOutput("ovf", int'(ovf), int'(e.ovf));
         end
      end
   end

   initial begin
      int edges;
      int busyCnt;
      int doneSeen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rd;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;

      // Reset state, observed before any clock edge.
      #2;
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstDiff", int'(diff), 0);
      checkOutput("rstBorrow", int'(borrow), 0);
      checkOutput("rstOvf", int'(ovf), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic operation with latency and busy length.
      applyStimulus(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0);
      waitDone(edges, busyCnt);
      checkOutput("latency35", edges, 8);
      checkOutput("busyCycles35", busyCnt, 8);
      @(posedge clk);
      #1;
      checkOutput("idleBusy", int'(busy), 0);
      checkOutput("idleDone", int'(done), 0);

      // Borrow case, with results held during the next shift.
      applyStimulus(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("diffHold", int'(diff), 'h23);
      checkOutput("borrowHold", int'(borrow), 0);
      waitDone(edges, busyCnt);
      checkOutput("latency00", edges, 7);

      // Signed overflow case.
      applyStimulus(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
      waitDone(edges, busyCnt);
      checkOutput("latency80", edges, 8);

      // Start during SHIFT is ignored.
      applyStimulus(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busyIgnored", int'(busy), 1);
      waitDone(edges, busyCnt);
      checkOutput("latencyIgnored", edges, 5);
      @(posedge clk);
      #1;

      // Back-to-back with start held high; operands change mid-shift.
      applyStimulus(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      a = 8'h09;
      b = 8'h0A;
      waitDone(edges, busyCnt);
      checkOutput("latencyB2B1", edges, 8);
      @(posedge clk);
      #1;
      pushExpected(8'hFF, 1'b1, 1'b0);
      checkOutput("b2bRestart", int'(busy), 1);
      waitDone(edges, busyCnt);
      checkOutput("latencyB2B2", edges, 8);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("b2bIdle", int'(busy), 0);

      // Reset mid-shift abandons the operation; restart on the first edge afterwards.
      @(negedge clk);
      a     = 8'h35;
      b     = 8'h12;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstDone", int'(done), 0);
      checkOutput("midRstDiff", int'(diff), 0);
      checkOutput("midRstBorrow", int'(borrow), 0);
      checkOutput("midRstOvf", int'(ovf), 0);
      a     = 8'h7F;
      b     = 8'h80;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      pushExpected(8'hFF, 1'b1, 1'b1);
      checkOutput("acceptAfterRst", int'(busy), 1);
      waitDone(edges, busyCnt);
      checkOutput("latencyAfterRst", edges, 8);
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) doneSeen++;
      end
      checkOutput("noStrayDone", doneSeen, 0);

      // Random operands against reference arithmetic.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rd = ra - rb;
         applyStimulus(ra, rb, rd, (ra < rb), (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]), 1'b0);
         waitDone(edges, busyCnt);
         if (edges != 8) checkOutput("latencyRand", edges, 8);
      end

      repeat (3) @(posedge clk);
      checkOutput("queueEmpty", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
